// File: rtl/gnr_cycle_detector_if.sv
// Host and node-array signals of the GNR cycle detector.
// master: host/node-array side, slave: the detector.
interface gnr_cycle_detector_if #(
  parameter int unsigned NUM_NODES = 16,
  parameter int unsigned CNT_WIDTH = 16
);

  // Host side
  logic                 start;
  logic [NUM_NODES-1:0] init_vec;
  logic                 busy;
  logic                 done;
  logic                 timeout;
  logic [CNT_WIDTH-1:0] meet_steps;
  logic [CNT_WIDTH-1:0] period;

  // Node-array side
  logic [NUM_NODES-1:0] s0_vec;
  logic [NUM_NODES-1:0] s1_vec;
  logic                 reset_nos;
  logic [NUM_NODES-1:0] init_state;
  logic                 start_s0;
  logic                 start_s1;

  modport master (
    output start, init_vec, s0_vec, s1_vec,
    input  busy, done, timeout, meet_steps, period,
    input  reset_nos, init_state, start_s0, start_s1
  );

  modport slave (
    input  start, init_vec, s0_vec, s1_vec,
    output busy, done, timeout, meet_steps, period,
    output reset_nos, init_state, start_s0, start_s1
  );

endinterface

// File: rtl/gnr_cycle_detector.sv
// Run controller and Floyd attractor detector for the Boolean GNR node array.
// Steps the tortoise/hare copies, reports the meeting hare step and the period.
module gnr_cycle_detector #(
  parameter int unsigned NUM_NODES = 16,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned MAX_STEPS = 1000
) (
  input logic                clk,
  input logic                rst,
  gnr_cycle_detector_if.slave if_bus
);

  localparam logic [CNT_WIDTH-1:0] LP_MAX  = CNT_WIDTH'(MAX_STEPS);
  localparam logic [CNT_WIDTH-1:0] LP_ZERO = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] LP_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LP_TWO  = CNT_WIDTH'(2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_MU_STEP  = 3'd2,
    S_MU_CHK   = 3'd3,
    S_LAM_STEP = 3'd4,
    S_LAM_CHK  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_hare_cnt;
  logic [CNT_WIDTH-1:0] r_lam_cnt;
  logic [CNT_WIDTH-1:0] r_meet_steps;
  logic [CNT_WIDTH-1:0] r_period;
  logic                 r_timeout;
  logic [NUM_NODES-1:0] r_init_state;
  logic                 r_reset_nos;
  logic                 r_start_s0;
  logic                 r_start_s1;
  logic                 r_busy;
  logic                 r_done;

  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] w_hare_cnt_nxt;
  logic [CNT_WIDTH-1:0] w_lam_cnt_nxt;
  logic [CNT_WIDTH-1:0] w_meet_steps_nxt;
  logic [CNT_WIDTH-1:0] w_period_nxt;
  logic                 w_timeout_nxt;
  logic [NUM_NODES-1:0] w_init_state_nxt;
  logic                 w_reset_nos_nxt;
  logic                 w_start_s0_nxt;
  logic                 w_start_s1_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic                 w_match;

  assign w_match = (if_bus.s0_vec == if_bus.s1_vec);

  // State, counters, results and registered controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_hare_cnt   <= LP_ZERO;
      r_lam_cnt    <= LP_ZERO;
      r_meet_steps <= LP_ZERO;
      r_period     <= LP_ZERO;
      r_timeout    <= 1'b0;
      r_init_state <= NUM_NODES'(0);
      r_reset_nos  <= 1'b0;
      r_start_s0   <= 1'b0;
      r_start_s1   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hare_cnt   <= w_hare_cnt_nxt;
      r_lam_cnt    <= w_lam_cnt_nxt;
      r_meet_steps <= w_meet_steps_nxt;
      r_period     <= w_period_nxt;
      r_timeout    <= w_timeout_nxt;
      r_init_state <= w_init_state_nxt;
      r_reset_nos  <= w_reset_nos_nxt;
      r_start_s0   <= w_start_s0_nxt;
      r_start_s1   <= w_start_s1_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  // Next state and datapath; controls are decoded from the next state so they register cleanly
  always_comb begin
    w_state_nxt      = r_state;
    w_hare_cnt_nxt   = r_hare_cnt;
    w_lam_cnt_nxt    = r_lam_cnt;
    w_meet_steps_nxt = r_meet_steps;
    w_period_nxt     = r_period;
    w_timeout_nxt    = r_timeout;
    w_init_state_nxt = r_init_state;

    case (r_state)
      S_IDLE: begin
        if (if_bus.start) begin
          w_state_nxt      = S_INIT;
          w_init_state_nxt = if_bus.init_vec;
          w_hare_cnt_nxt   = LP_ZERO;
          w_lam_cnt_nxt    = LP_ZERO;
          w_period_nxt     = LP_ZERO;
          w_meet_steps_nxt = LP_ZERO;
          w_timeout_nxt    = 1'b0;
        end
      end
      S_INIT: begin
        w_state_nxt = S_MU_STEP;
      end
      S_MU_STEP: begin
        w_hare_cnt_nxt = (r_hare_cnt == LP_MAX) ? r_hare_cnt : r_hare_cnt + LP_ONE;
        w_state_nxt    = S_MU_CHK;
      end
      S_MU_CHK: begin
        // After one hare step both copies sit at step 1, so that match is meaningless
        if (w_match && (r_hare_cnt >= LP_TWO)) begin
          w_meet_steps_nxt = r_hare_cnt;
          w_lam_cnt_nxt    = LP_ZERO;
          w_state_nxt      = S_LAM_STEP;
        end else if (r_hare_cnt == LP_MAX) begin
          w_timeout_nxt    = 1'b1;
          w_meet_steps_nxt = LP_ZERO;
          w_state_nxt      = S_DONE;
        end else begin
          w_state_nxt = S_MU_STEP;
        end
      end
      S_LAM_STEP: begin
        w_lam_cnt_nxt = (r_lam_cnt == LP_MAX) ? r_lam_cnt : r_lam_cnt + LP_ONE;
        w_state_nxt   = S_LAM_CHK;
      end
      S_LAM_CHK: begin
        if (w_match) begin
          w_period_nxt = r_lam_cnt;
          w_state_nxt  = S_DONE;
        end else if (r_lam_cnt == LP_MAX) begin
          w_timeout_nxt = 1'b1;
          w_period_nxt  = LP_ZERO;
          w_state_nxt   = S_DONE;
        end else begin
          w_state_nxt = S_LAM_STEP;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_reset_nos_nxt = (w_state_nxt == S_INIT);
    w_start_s0_nxt  = (w_state_nxt == S_MU_STEP);
    w_start_s1_nxt  = (w_state_nxt == S_MU_STEP) || (w_state_nxt == S_LAM_STEP);
    w_busy_nxt      = (w_state_nxt == S_INIT)     || (w_state_nxt == S_MU_STEP) ||
                      (w_state_nxt == S_MU_CHK)   || (w_state_nxt == S_LAM_STEP) ||
                      (w_state_nxt == S_LAM_CHK);
    w_done_nxt      = (w_state_nxt == S_DONE);
  end

  assign if_bus.reset_nos  = r_reset_nos;
  assign if_bus.init_state = r_init_state;
  assign if_bus.start_s0   = r_start_s0;
  assign if_bus.start_s1   = r_start_s1;
  assign if_bus.busy       = r_busy;
  assign if_bus.done       = r_done;
  assign if_bus.timeout    = r_timeout;
  assign if_bus.meet_steps = r_meet_steps;
  assign if_bus.period     = r_period;

endmodule

// File: tb/tb_gnr_cycle_detector.sv
// Bench for gnr_cycle_detector: 4-node networks given as lookup tables,
// two detector instances (large and small step bound), scoreboard checking.
module tb_gnr_cycle_detector;

  localparam int unsigned NN    = 4;
  localparam int unsigned CW    = 16;
  localparam int unsigned MAX_A = 1000;
  localparam int unsigned MAX_B = 6;

  typedef struct {
    int         meet;
    int         period;
    int         to;
    int         s0p;
    int         s1p;
    int         lat;
    int         start_cyc;
    logic [3:0] init;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [3:0] lut [2][16];
  logic       arm [2];
  exp_t       q [2][$];
  int         rn_cnt [2];
  int         s0_cnt [2];
  int         s1_cnt [2];
  int         clash_cnt [2];

  gnr_cycle_detector_if #(.NUM_NODES(NN), .CNT_WIDTH(CW)) if_a ();
  gnr_cycle_detector_if #(.NUM_NODES(NN), .CNT_WIDTH(CW)) if_b ();

  gnr_cycle_detector #(.NUM_NODES(NN), .CNT_WIDTH(CW), .MAX_STEPS(MAX_A)) u_dut_a (
    .clk(clk), .rst(rst), .if_bus(if_a)
  );
  gnr_cycle_detector #(.NUM_NODES(NN), .CNT_WIDTH(CW), .MAX_STEPS(MAX_B)) u_dut_b (
    .clk(clk), .rst(rst), .if_bus(if_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Node arrays: hare steps every pulse, tortoise on odd pulses since last reset_nos
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if_a.s0_vec <= '0; if_a.s1_vec <= '0; arm[0] <= 1'b1;
      if_b.s0_vec <= '0; if_b.s1_vec <= '0; arm[1] <= 1'b1;
    end else begin
      if (if_a.reset_nos) begin
        if_a.s0_vec <= if_a.init_state; if_a.s1_vec <= if_a.init_state; arm[0] <= 1'b1;
      end else begin
        if (if_a.start_s1) if_a.s1_vec <= lut[0][if_a.s1_vec];
        if (if_a.start_s0) begin
          arm[0] <= ~arm[0];
          if (arm[0]) if_a.s0_vec <= lut[0][if_a.s0_vec];
        end
      end
      if (if_b.reset_nos) begin
        if_b.s0_vec <= if_b.init_state; if_b.s1_vec <= if_b.init_state; arm[1] <= 1'b1;
      end else begin
        if (if_b.start_s1) if_b.s1_vec <= lut[1][if_b.s1_vec];
        if (if_b.start_s0) begin
          arm[1] <= ~arm[1];
          if (arm[1]) if_b.s0_vec <= lut[1][if_b.s0_vec];
        end
      end
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: walk the trajectory x_k and apply the tortoise/hare rules directly
  function automatic exp_t model(int d, logic [3:0] init, int mx);
    exp_t       e = '{default: 0};
    logic [3:0] seq [0:2047];
    logic [3:0] t;
    int         mu = 0;
    int         lam = 0;
    seq[0] = init;
    for (int i = 1; i <= 2 * mx && i < 2048; i++) seq[i] = lut[d][seq[i-1]];
    for (int k = 2; k <= mx; k++) begin
      if (seq[k] == seq[(k + 1) / 2]) begin mu = k; break; end
    end
    e.init = init;
    if (mu == 0) begin
      e.to = 1; e.s0p = mx; e.s1p = mx;
    end else begin
      t = seq[(mu + 1) / 2];
      for (int j = 1; j <= mx; j++) begin
        if (seq[mu + j] == t) begin lam = j; break; end
      end
      e.meet = mu; e.s0p = mu;
      if (lam == 0) begin e.to = 1; e.s1p = mu + mx; end
      else begin e.period = lam; e.s1p = mu + lam; end
    end
    e.lat = 2 + 2 * e.s1p;
    return e;
  endfunction

  task automatic mon(int d, logic dn, logic bz, logic rs, logic s0, logic s1,
                     logic [CW-1:0] meet, logic [CW-1:0] per, logic to, logic [NN-1:0] ini);
    exp_t e;
    if (rst) begin
      rn_cnt[d] = 0; s0_cnt[d] = 0; s1_cnt[d] = 0; clash_cnt[d] = 0;
    end else begin
      if (rs) rn_cnt[d]++;
      if (s0) s0_cnt[d]++;
      if (s1) s1_cnt[d]++;
      if (rs && (s0 || s1)) clash_cnt[d]++;
      if (dn) begin
        check($sformatf("d%0d_done_expected", d), 64'(q[d].size() != 0), 64'd1);
        if (q[d].size() != 0) begin
          e = q[d].pop_front();
          check($sformatf("d%0d_meet", d),    64'(meet), 64'(e.meet));
          check($sformatf("d%0d_period", d),  64'(per), 64'(e.period));
          check($sformatf("d%0d_timeout", d), 64'(to), 64'(e.to));
          check($sformatf("d%0d_latency", d), 64'(cyc - e.start_cyc), 64'(e.lat));
          check($sformatf("d%0d_init", d),    64'(ini), 64'(e.init));
          check($sformatf("d%0d_busy_at_done", d), 64'(bz), 64'd0);
          check($sformatf("d%0d_reset_nos_cycles", d), 64'(rn_cnt[d]), 64'd1);
          check($sformatf("d%0d_s0_pulses", d), 64'(s0_cnt[d]), 64'(e.s0p));
          check($sformatf("d%0d_s1_pulses", d), 64'(s1_cnt[d]), 64'(e.s1p));
          check($sformatf("d%0d_ctrl_overlap", d), 64'(clash_cnt[d]), 64'd0);
        end
        rn_cnt[d] = 0; s0_cnt[d] = 0; s1_cnt[d] = 0; clash_cnt[d] = 0;
      end
    end
  endtask

  // Monitor: sample away from the active edge and score every done pulse
  always @(negedge clk) begin
    mon(0, if_a.done, if_a.busy, if_a.reset_nos, if_a.start_s0, if_a.start_s1,
        if_a.meet_steps, if_a.period, if_a.timeout, if_a.init_state);
    mon(1, if_b.done, if_b.busy, if_b.reset_nos, if_b.start_s0, if_b.start_s1,
        if_b.meet_steps, if_b.period, if_b.timeout, if_b.init_state);
  end

  task automatic drive_start(int d, logic v, logic [3:0] init);
    if (d == 0) begin if_a.start = v; if_a.init_vec = init; end
    else        begin if_b.start = v; if_b.init_vec = init; end
  endtask

  task automatic launch(int d, logic [3:0] init, output exp_t e);
    e = model(d, init, (d == 0) ? int'(MAX_A) : int'(MAX_B));
    @(negedge clk);
    drive_start(d, 1'b1, init);
    e.start_cyc = cyc;
    q[d].push_back(e);
    @(negedge clk);
    drive_start(d, 1'b0, init);
  endtask

  task automatic wait_done(int d, int budget);
    int n = 0;
    while (q[d].size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("d%0d_done_within_budget", d), 64'(q[d].size()), 64'd0);
    q[d].delete();
    @(negedge clk);
  endtask

  task automatic set_mod4(int d);
    for (int j = 0; j < 16; j++) lut[d][j] = 4'((j + 1) % 4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    logic [3:0] ini;
    if_a.start = 1'b0; if_a.init_vec = '0;
    if_b.start = 1'b0; if_b.init_vec = '0;
    for (int j = 0; j < 16; j++) begin lut[0][j] = 4'(j); lut[1][j] = 4'(j); end

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("reset_outputs_a", 64'({if_a.busy, if_a.done, if_a.timeout, if_a.reset_nos, if_a.start_s0,
          if_a.start_s1, if_a.meet_steps, if_a.period, if_a.init_state}), 64'd0);
    check("reset_outputs_b", 64'({if_b.busy, if_b.done, if_b.timeout, if_b.reset_nos, if_b.start_s0,
          if_b.start_s1, if_b.meet_steps, if_b.period, if_b.init_state}), 64'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Identity network: fixed point
    launch(0, 4'hA, e);
    wait_done(0, e.lat + 20);

    // Mod-4 counter from 0
    set_mod4(0);
    launch(0, 4'h0, e);
    wait_done(0, e.lat + 20);
    repeat (5) @(negedge clk);
    check("results_hold_meet", 64'(if_a.meet_steps), 64'(e.meet));
    check("results_hold_period", 64'(if_a.period), 64'(e.period));

    // Mod-4 counter against the small step bound
    set_mod4(1);
    launch(1, 4'h0, e);
    wait_done(1, e.lat + 20);

    // Transient into a two-cycle
    for (int j = 0; j < 16; j++) lut[0][j] = 4'h0;
    lut[0][0] = 4'h5; lut[0][5] = 4'h6; lut[0][6] = 4'h7; lut[0][7] = 4'h6;
    launch(0, 4'h0, e);
    wait_done(0, e.lat + 20);

    // Reset during the period search aborts the run
    set_mod4(0);
    launch(0, 4'h1, e);
    n = 0;
    while (!(if_a.start_s1 && !if_a.start_s0 && if_a.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_lam_step", 64'(n < 200), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("midrun_reset_outputs", 64'({if_a.busy, if_a.done, if_a.timeout, if_a.reset_nos,
          if_a.start_s0, if_a.start_s1, if_a.meet_steps, if_a.period, if_a.init_state}), 64'd0);
    q[0].delete();
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    launch(0, 4'h2, e);
    wait_done(0, e.lat + 20);

    // Start while busy and coincident with done are both ignored
    launch(0, 4'h0, e);
    while (cyc < e.start_cyc + 5) @(negedge clk);
    drive_start(0, 1'b1, 4'hF);
    @(negedge clk);
    drive_start(0, 1'b0, 4'hF);
    while (cyc < e.start_cyc + e.lat) @(negedge clk);
    drive_start(0, 1'b1, 4'hE);
    @(negedge clk);
    drive_start(0, 1'b0, 4'hE);
    wait_done(0, 40);
    repeat (60) @(negedge clk);
    check("ignored_start_init_state", 64'(if_a.init_state), 64'h0);
    check("ignored_start_idle", 64'(if_a.busy), 64'd0);

    // Random networks, large bound
    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < 16; j++) lut[0][j] = 4'($urandom_range(0, 15));
      ini = 4'($urandom_range(0, 15));
      launch(0, ini, e);
      wait_done(0, e.lat + 20);
    end

    // Random networks, small bound
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 16; j++) lut[1][j] = 4'($urandom_range(0, 15));
      ini = 4'($urandom_range(0, 15));
      launch(1, ini, e);
      wait_done(1, e.lat + 20);
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
